dmem_wait_responder: RTL



---
 rtl/dmem_wait_responder_pkg.sv | 11 +
 rtl/dmem_wait_responder_array.sv | 30 +++
 rtl/dmem_wait_responder.sv | 118 +++++++++++
 3 files changed

// File: rtl/dmem_wait_responder_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
package dmem_wait_responder_pkg;
  localparam int ADDR_W = 7;
  localparam int DW     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_wait_responder_array.sv
// 128x32 storage with synchronous write and a registered read port that
// doubles as the responder's read-data holding register.
module dmem_array_128x32 #(
  parameter int WORDS  = 128,
  parameter int DW     = 32,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DW-1:0]     wdata,
  output logic [DW-1:0]     rdata
);
  logic [DW-1:0] mem [0:WORDS-1];
  logic [DW-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata_reg <= '0;
    else if (re) rdata_reg <= mem[addr];
  end

  assign rdata = rdata_reg;
endmodule

// File: rtl/dmem_wait_responder.sv
// Data-memory target with LAT programmable wait states; stall holds the CPU
// until the access completes in the single-cycle DONE slot.
module dmem_wait_responder #(
  parameter int LAT   = 2,
  parameter int WORDS = 128,
  parameter int DW    = dmem_wait_responder_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          wen,
  input  logic          oen,
  input  logic [6:0]    a,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q,
  output logic          stall
);
  import dmem_wait_responder_pkg::*;

  localparam int CNT_W = 4;

  generate
    if (LAT < 1 || LAT > 15) begin : g_bad_lat
      $error("dmem_wait_responder: LAT must be in 1..15");
    end
  endgenerate

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DW-1:0]       data_reg, data_next;
  logic                wen_reg, wen_next;

  logic                acc_en, acc_wen;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DW-1:0]       acc_data;
  logic [DW-1:0]       rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      wen_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      wen_reg   <= wen_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    wen_next   = wen_reg;
    case (state_reg)
      IDLE: if (!cen) begin
        addr_next  = a;
        data_next  = d;
        wen_next   = wen;
        cnt_next   = CNT_W'(LAT - 1);
        state_next = (LAT == 1) ? DONE : WAIT;
      end
      WAIT: begin
        if (cnt_reg == 4'd1) state_next = DONE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With LAT=1 the access happens on the accept edge, so it uses live inputs.
  always_comb begin
    stall    = 1'b0;
    acc_en   = 1'b0;
    acc_addr = addr_reg;
    acc_data = data_reg;
    acc_wen  = wen_reg;
    case (state_reg)
      IDLE: if (!cen) begin
        stall = 1'b1;
        if (LAT == 1) begin
          acc_en   = 1'b1;
          acc_addr = a;
          acc_data = d;
          acc_wen  = wen;
        end
      end
      WAIT: begin
        stall  = 1'b1;
        acc_en = (cnt_reg == 4'd1);
      end
      default: ;
    endcase
  end

  dmem_array_128x32 #(
    .WORDS  (WORDS),
    .DW     (DW),
    .ADDR_W (ADDR_W)
  ) mem_u (
    .clk   (clk),
    .rst   (rst),
    .we    (acc_en && !acc_wen && !rst),
    .re    (acc_en && acc_wen && !rst),
    .addr  (acc_addr),
    .wdata (acc_data),
    .rdata (rdata)
  );

  assign q = oen ? '0 : rdata;
endmodule
